// File: rtl/axis_pkg.sv
// Shared definitions for the AXI4-Stream frame sink: FSM state type,
// default frame length and the pointer-width helper.
package axis_pkg;

    // RECV: accepting beats into the buffer; HOLD: frame complete, read port active
    typedef enum logic {
        RECV = 1'b0,
        HOLD = 1'b1
    } sink_state_t;

    localparam int FRAME_WORDS_DEFAULT = 8;

    // Pointers must represent 0..depth inclusive (depth = "buffer full")
    function automatic int ptr_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/axis_frame_buffer.sv
// Frame storage: DEPTH x DATA_WIDTH array with one write port and a
// registered read port. The read register only updates on rd_en, so the
// last word read stays on rd_data until the next read.
module axis_frame_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [AW-1:0]         rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_reg;

    // Write port: store the accepted beat at the current write slot
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port; output register cleared on reset
    always_ff @(posedge clk) begin
        if (srst) begin
            rd_data_reg <= '0;
        end else if (rd_en) begin
            rd_data_reg <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_reg;

endmodule

// File: rtl/axis_frame_sink.sv
// AXI4-Stream slave terminating a fixed-length frame stream. One frame is
// captured into a local buffer while its length and 1..N data sequence are
// checked; the frame is then held (TREADY low) until it has been fully read
// out through the simple rd_en/rd_data port.
module axis_frame_sink
    import axis_pkg::*;
#(
    parameter int C_S_AXIS_TDATA_WIDTH = 32,
    parameter int FRAME_WORDS          = FRAME_WORDS_DEFAULT,
    parameter bit CHECK_SEQ            = 1'b1
) (
    input  logic                              S_AXIS_ACLK,
    input  logic                              S_AXIS_ARESET,
    input  logic                              S_AXIS_TVALID,
    output logic                              S_AXIS_TREADY,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   S_AXIS_TDATA,
    input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0] S_AXIS_TSTRB,
    input  logic                              S_AXIS_TLAST,
    input  logic                              rd_en,
    output logic [C_S_AXIS_TDATA_WIDTH-1:0]   rd_data,
    output logic                              rd_valid,
    output logic                              frame_done,
    output logic                              frame_err,
    output logic                              seq_err,
    output logic [15:0]                       frame_count
);

    localparam int W  = C_S_AXIS_TDATA_WIDTH;
    localparam int PW = ptr_width(FRAME_WORDS);
    localparam int AW = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam logic [PW-1:0] LAST_IDX = PW'(FRAME_WORDS - 1);

    sink_state_t     state_reg;
    logic [PW-1:0]   wr_ptr_reg;
    logic [PW-1:0]   rd_ptr_reg;
    logic            frame_err_reg;
    logic            seq_err_reg;
    logic            rd_valid_reg;
    logic [15:0]     frame_count_reg;

    logic            beat_fire;
    logic            at_last_slot;
    logic            frame_close;
    logic            len_err_beat;
    logic            seq_bad_beat;
    logic            rd_fire;
    logic            rd_last;

    // Byte qualifiers carry no meaning for this sink
    logic            unused_tstrb;
    assign unused_tstrb = ^S_AXIS_TSTRB;

    // Ready only while collecting a frame and never during reset
    assign S_AXIS_TREADY = (state_reg == RECV) && !S_AXIS_ARESET;

    assign beat_fire    = S_AXIS_TVALID && S_AXIS_TREADY;
    assign at_last_slot = (wr_ptr_reg == LAST_IDX);

    // A frame ends on TLAST or when the buffer's final slot is filled,
    // whichever comes first; the mismatch of the two is a length error.
    assign frame_close  = beat_fire && (S_AXIS_TLAST || at_last_slot);
    assign len_err_beat = (S_AXIS_TLAST && (wr_ptr_reg < LAST_IDX)) ||
                          (at_last_slot && !S_AXIS_TLAST);

    // Beat k of a frame is expected to carry the value k+1
    generate
        if (CHECK_SEQ) begin : g_seq_check
            assign seq_bad_beat = (S_AXIS_TDATA != (W'(wr_ptr_reg) + W'(1)));
        end else begin : g_no_seq_check
            assign seq_bad_beat = 1'b0;
        end
    endgenerate

    // Reads are honoured only while a frame is held and words remain
    assign rd_fire = (state_reg == HOLD) && rd_en && (rd_ptr_reg < wr_ptr_reg);
    assign rd_last = rd_fire && (rd_ptr_reg == (wr_ptr_reg - PW'(1)));

    axis_frame_buffer #(
        .DATA_WIDTH (W),
        .DEPTH      (FRAME_WORDS)
    ) u_buffer (
        .clk     (S_AXIS_ACLK),
        .srst    (S_AXIS_ARESET),
        .wr_en   (beat_fire),
        .wr_addr (wr_ptr_reg[AW-1:0]),
        .wr_data (S_AXIS_TDATA),
        .rd_en   (rd_fire),
        .rd_addr (rd_ptr_reg[AW-1:0]),
        .rd_data (rd_data)
    );

    // Receive/hold FSM with pointers, error accumulation and frame counter
    always_ff @(posedge S_AXIS_ACLK) begin
        if (S_AXIS_ARESET) begin
            state_reg       <= RECV;
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            frame_err_reg   <= 1'b0;
            seq_err_reg     <= 1'b0;
            rd_valid_reg    <= 1'b0;
            frame_count_reg <= '0;
        end else begin
            rd_valid_reg <= rd_fire;
            case (state_reg)
                RECV: begin
                    if (beat_fire) begin
                        wr_ptr_reg  <= wr_ptr_reg + PW'(1);
                        seq_err_reg <= seq_err_reg | seq_bad_beat;
                        if (frame_close) begin
                            frame_err_reg   <= frame_err_reg | len_err_beat;
                            frame_count_reg <= frame_count_reg + 16'd1;
                            state_reg       <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (rd_fire) begin
                        rd_ptr_reg <= rd_ptr_reg + PW'(1);
                    end
                    // Last stored word read: release the buffer for the next frame
                    if (rd_last) begin
                        state_reg     <= RECV;
                        wr_ptr_reg    <= '0;
                        rd_ptr_reg    <= '0;
                        frame_err_reg <= 1'b0;
                        seq_err_reg   <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= RECV;
                end
            endcase
        end
    end

    assign rd_valid    = rd_valid_reg;
    assign frame_done  = (state_reg == HOLD);
    assign frame_err   = frame_err_reg;
    assign seq_err     = seq_err_reg;
    assign frame_count = frame_count_reg;

endmodule

// File: tb/tb_axis_frame_sink.sv
// Bench for axis_frame_sink: beat lists are split into expected frames
// by a behavioural model, then driven with random gaps while a reader
// drains and checks each held frame.
module tb_axis_frame_sink;

    localparam int W  = 32;
    localparam int FW = 8;

    logic           clk = 1'b0;
    logic           areset;
    logic           tvalid;
    logic           tready;
    logic [W-1:0]   tdata;
    logic [W/8-1:0] tstrb;
    logic           tlast;
    logic           rd_en;
    logic [W-1:0]   rd_data;
    logic           rd_valid;
    logic           frame_done;
    logic           frame_err;
    logic           seq_err;
    logic [15:0]    frame_count;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_count;
    logic [W-1:0] last_rd;

    logic [W-1:0] beat_data[$];
    bit           beat_last[$];
    logic [W-1:0] exp_words[$];
    int           exp_len[$];
    bit           exp_ferr[$];
    bit           exp_serr[$];

    axis_frame_sink #(
        .C_S_AXIS_TDATA_WIDTH (W),
        .FRAME_WORDS          (FW),
        .CHECK_SEQ            (1'b1)
    ) dut (
        .S_AXIS_ACLK   (clk),
        .S_AXIS_ARESET (areset),
        .S_AXIS_TVALID (tvalid),
        .S_AXIS_TREADY (tready),
        .S_AXIS_TDATA  (tdata),
        .S_AXIS_TSTRB  (tstrb),
        .S_AXIS_TLAST  (tlast),
        .rd_en         (rd_en),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid),
        .frame_done    (frame_done),
        .frame_err     (frame_err),
        .seq_err       (seq_err),
        .frame_count   (frame_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Split the beat list into frames: a frame ends at TLAST or after FW beats
    task automatic build_expected();
        int cur = 0;
        bit sbad = 0;
        logic [W-1:0] want;
        exp_words.delete(); exp_len.delete(); exp_ferr.delete(); exp_serr.delete();
        for (int i = 0; i < beat_data.size(); i++) begin
            want = W'(cur + 1);
            exp_words.push_back(beat_data[i]);
            if (beat_data[i] != want) sbad = 1;
            cur++;
            if (beat_last[i] || cur == FW) begin
                exp_len.push_back(cur);
                exp_ferr.push_back((beat_last[i] && cur < FW) || (cur == FW && !beat_last[i]));
                exp_serr.push_back(sbad);
                cur = 0;
                sbad = 0;
            end
        end
    endtask

    task automatic push_frame(input int len, input bit with_last, input int bad_idx, input logic [W-1:0] bad_val);
        for (int k = 0; k < len; k++) begin
            beat_data.push_back((k == bad_idx) ? bad_val : W'(k + 1));
            beat_last.push_back(with_last && (k == len - 1));
        end
    endtask

    task automatic drive_beats(input bit nogap);
        int n;
        for (int i = 0; i < beat_data.size(); i++) begin
            if (!nogap) begin
                int gap = $urandom_range(0, 2);
                repeat (gap) begin
                    tvalid = 1'b0;
                    @(posedge clk); #1;
                end
            end
            tvalid = 1'b1;
            tdata  = beat_data[i];
            tlast  = beat_last[i];
            tstrb  = 4'($urandom);
            n = 0;
            while (!tready && n < 300) begin
                @(posedge clk); #1;
                n++;
            end
            n_checks++;
            if (!tready) begin
                n_fail++;
                $display("FAIL beat_accept: beat %0d tready=%0b required 1 within 300 cycles", i, tready);
                tvalid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    task automatic read_frames(input int max_hold);
        int wi = 0;
        for (int f = 0; f < exp_len.size(); f++) begin
            int n = 0;
            int issued = 0;
            int got = 0;
            int hold;
            bit pend;
            while (!frame_done && n < 300) begin
                @(posedge clk); #1;
                n++;
            end
            n_checks++;
            if (!frame_done) begin
                n_fail++;
                $display("FAIL frame_done_wait: frame %0d frame_done=%0b required 1", f, frame_done);
                return;
            end
            exp_count++;
            n_checks++;
            if (frame_count !== 16'(exp_count)) begin
                n_fail++;
                $display("FAIL frame_count: got %0d required %0d", frame_count, exp_count);
            end
            n_checks++;
            if (frame_err !== exp_ferr[f]) begin
                n_fail++;
                $display("FAIL frame_err: frame %0d got %0b required %0b", f, frame_err, exp_ferr[f]);
            end
            n_checks++;
            if (seq_err !== exp_serr[f]) begin
                n_fail++;
                $display("FAIL seq_err: frame %0d got %0b required %0b", f, seq_err, exp_serr[f]);
            end
            hold = $urandom_range(0, max_hold);
            repeat (hold) begin
                @(posedge clk); #1;
                n_checks++;
                if (tready !== 1'b0 || frame_done !== 1'b1 || rd_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL hold_state: tready=%0b frame_done=%0b rd_valid=%0b required 0/1/0",
                             tready, frame_done, rd_valid);
                end
            end
            n = 0;
            while (got < exp_len[f] && n < 300) begin
                rd_en = (issued < exp_len[f]) ? ($urandom_range(0, 3) != 0) : 1'b0;
                pend  = rd_en;
                if (rd_en) issued++;
                @(posedge clk); #1;
                rd_en = 1'b0;
                n++;
                n_checks++;
                if (pend) begin
                    if (rd_valid !== 1'b1 || rd_data !== exp_words[wi + got]) begin
                        n_fail++;
                        $display("FAIL rd_word: frame %0d word %0d rd_valid=%0b rd_data=%0h required 1/%0h",
                                 f, got, rd_valid, rd_data, exp_words[wi + got]);
                    end
                    last_rd = exp_words[wi + got];
                    got++;
                end else begin
                    if (rd_valid !== 1'b0 || rd_data !== last_rd) begin
                        n_fail++;
                        $display("FAIL rd_idle: rd_valid=%0b rd_data=%0h required 0/%0h", rd_valid, rd_data, last_rd);
                    end
                end
            end
            n_checks++;
            if (frame_done !== 1'b0 || tready !== 1'b1) begin
                n_fail++;
                $display("FAIL drain_release: frame_done=%0b tready=%0b required 0/1", frame_done, tready);
            end
            $display("frame %0d: len=%0d ferr=%0b serr=%0b count=%0d", f, exp_len[f], exp_ferr[f], exp_serr[f], exp_count);
            wi += exp_len[f];
        end
    endtask

    task automatic run_stream(input bit nogap, input int max_hold);
        build_expected();
        fork
            drive_beats(nogap);
            read_frames(max_hold);
        join
        beat_data.delete();
        beat_last.delete();
    endtask

    task automatic test_reset();
        areset = 1'b1;
        tvalid = 1'b0; tdata = '0; tstrb = '0; tlast = 1'b0; rd_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (tready !== 1'b0 || frame_done !== 1'b0 || rd_valid !== 1'b0 || frame_count !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: tready=%0b frame_done=%0b rd_valid=%0b count=%0d required 0/0/0/0",
                     tready, frame_done, rd_valid, frame_count);
        end
        areset = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (tready !== 1'b1 || rd_data !== '0 || frame_err !== 1'b0 || seq_err !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset: tready=%0b rd_data=%0h ferr=%0b serr=%0b required 1/0/0/0",
                     tready, rd_data, frame_err, seq_err);
        end
        exp_count = 0;
        last_rd = '0;
        $display("reset: tready=%0b count=%0d", tready, frame_count);
    endtask

    task automatic test_basic_frame();
        push_frame(8, 1, -1, '0);
        run_stream(0, 3);
    endtask

    task automatic test_hold_backpressure();
        push_frame(8, 1, -1, '0);
        push_frame(8, 1, -1, '0);
        run_stream(1, 6);
    endtask

    task automatic test_short_frame();
        push_frame(5, 1, -1, '0);
        run_stream(0, 2);
    endtask

    task automatic test_missing_tlast();
        push_frame(8, 0, -1, '0);
        push_frame(8, 1, -1, '0);
        run_stream(0, 2);
    endtask

    task automatic test_seq_error();
        push_frame(8, 1, 2, 32'd7);
        push_frame(8, 1, -1, '0);
        run_stream(0, 2);
    endtask

    task automatic test_reset_midframe();
        push_frame(4, 0, -1, '0);
        drive_beats(0);
        beat_data.delete();
        beat_last.delete();
        n_checks++;
        if (frame_done !== 1'b0 || frame_count !== 16'(exp_count)) begin
            n_fail++;
            $display("FAIL partial_frame: frame_done=%0b count=%0d required 0/%0d", frame_done, frame_count, exp_count);
        end
        areset = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (tready !== 1'b0 || frame_count !== 16'd0 || frame_done !== 1'b0 || rd_data !== '0 || rd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midframe_reset: tready=%0b count=%0d done=%0b rd_data=%0h rd_valid=%0b required 0/0/0/0/0",
                     tready, frame_count, frame_done, rd_data, rd_valid);
        end
        areset = 1'b0;
        @(posedge clk); #1;
        exp_count = 0;
        last_rd = '0;
        $display("midframe reset: count=%0d tready=%0b", frame_count, tready);
        push_frame(8, 1, -1, '0);
        run_stream(0, 2);
    endtask

    task automatic test_random();
        for (int f = 0; f < 12; f++) begin
            int len = $urandom_range(1, FW);
            bit lst = (len < FW) ? 1'b1 : 1'($urandom_range(0, 1));
            int bad = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len - 1) : -1;
            push_frame(len, lst, bad, W'($urandom_range(100, 200)));
        end
        run_stream(0, 3);
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_hold_backpressure();
        test_short_frame();
        test_missing_tlast();
        test_seq_error();
        test_reset_midframe();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
